// File: rtl/ids_bus_pkg.sv
// Shared definitions for the IDS bus arbiter: FSM state encoding, grant-id codes
// and the default burst quota.
package ids_bus_pkg;

  localparam int unsigned BURST_MAX_DEF = 16;

  // State encodings coincide with the o_gnt_id codes so the id decodes trivially.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GNT_SPI = 2'd1,
    ST_GNT_RV  = 2'd2,
    ST_GNT_DMA = 2'd3
  } arb_state_e;

  localparam logic [1:0] GNT_ID_NONE = 2'd0;
  localparam logic [1:0] GNT_ID_SPI  = 2'd1;
  localparam logic [1:0] GNT_ID_DMEM = 2'd2;
  localparam logic [1:0] GNT_ID_DMA  = 2'd3;

  typedef enum logic {
    LAST_DMEM = 1'b0,
    LAST_DMA  = 1'b1
  } last_e;

endpackage

// File: rtl/ids_quota_cnt.sv
// Burst quota counter: synchronous clear, count-enable, saturates at BURST_MAX-1
// and flags expiry while saturated.
module ids_quota_cnt #(
  parameter int unsigned BURST_MAX = 16,
  parameter int unsigned CNT_W     = $clog2(BURST_MAX)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/ids_qos_arbiter.sv
// Three-master bus arbiter: SPI debug has fixed top priority, DMEM and DMA share
// the bus round-robin with a burst quota and a lock that defers preemption.
module ids_qos_arbiter
  import ids_bus_pkg::*;
#(
  parameter int unsigned BURST_MAX = BURST_MAX_DEF,
  parameter int unsigned CNT_W     = $clog2(BURST_MAX)
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req_spi,
  input  logic       i_req_dmem,
  input  logic       i_req_dma,
  input  logic       i_lock,
  output logic       o_gnt_spi,
  output logic       o_gnt_dmem,
  output logic       o_gnt_dma,
  output logic [1:0] o_gnt_id,
  output logic       o_busy
);

  arb_state_e state_q;
  arb_state_e state_d;
  last_e      last_q;
  logic       take;
  logic       quota_exp;
  logic       cnt_en;
  arb_state_e winner;

  always_comb begin
    if (i_req_spi) begin
      winner = ST_GNT_SPI;
    end else if (i_req_dmem && i_req_dma) begin
      winner = (last_q == LAST_DMA) ? ST_GNT_RV : ST_GNT_DMA;
    end else if (i_req_dmem) begin
      winner = ST_GNT_RV;
    end else if (i_req_dma) begin
      winner = ST_GNT_DMA;
    end else begin
      winner = ST_IDLE;
    end
  end

  // take marks an arbitration point; the counter restarts whenever one is taken.
  always_comb begin
    take    = 1'b0;
    state_d = state_q;
    case (state_q)
      ST_IDLE:    take = 1'b1;
      ST_GNT_SPI: take = !i_req_spi;
      ST_GNT_RV:  take = !i_req_dmem ||
                         (quota_exp && (i_req_spi || i_req_dma) && !i_lock);
      ST_GNT_DMA: take = !i_req_dma ||
                         (quota_exp && (i_req_spi || i_req_dmem) && !i_lock);
      default:    take = 1'b0;
    endcase
    if (take) begin
      state_d = winner;
    end
    if (!(state_q inside {ST_IDLE, ST_GNT_SPI, ST_GNT_RV, ST_GNT_DMA})) begin
      state_d = ST_IDLE;
    end
  end

  assign cnt_en = (state_q == ST_GNT_RV) || (state_q == ST_GNT_DMA);

  ids_quota_cnt #(
    .BURST_MAX (BURST_MAX),
    .CNT_W     (CNT_W)
  ) u_quota (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .clr_i     (take || (state_d != state_q)),
    .en_i      (cnt_en),
    .expired_o (quota_exp)
  );

  // Outputs are registered from the next state so they always mirror state_q.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      last_q     <= LAST_DMA;
      o_gnt_spi  <= 1'b0;
      o_gnt_dmem <= 1'b0;
      o_gnt_dma  <= 1'b0;
      o_gnt_id   <= GNT_ID_NONE;
      o_busy     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take && (state_d == ST_GNT_RV)) begin
        last_q <= LAST_DMEM;
      end else if (take && (state_d == ST_GNT_DMA)) begin
        last_q <= LAST_DMA;
      end
      o_gnt_spi  <= (state_d == ST_GNT_SPI);
      o_gnt_dmem <= (state_d == ST_GNT_RV);
      o_gnt_dma  <= (state_d == ST_GNT_DMA);
      case (state_d)
        ST_GNT_SPI: o_gnt_id <= GNT_ID_SPI;
        ST_GNT_RV:  o_gnt_id <= GNT_ID_DMEM;
        ST_GNT_DMA: o_gnt_id <= GNT_ID_DMA;
        default:    o_gnt_id <= GNT_ID_NONE;
      endcase
      o_busy <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_ids_qos_arbiter.sv
// Scoreboard bench for ids_qos_arbiter: directed vectors push expected grant ids,
// a negedge monitor pops and compares them and checks grant invariants.
module tb_ids_qos_arbiter;

  localparam int unsigned BMAX = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_spi, req_dmem, req_dma, lock;
  logic       gnt_spi, gnt_dmem, gnt_dma, busy;
  logic [1:0] gnt_id;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;

  typedef struct {
    int unsigned cyc;
    logic [1:0]  id;
  } exp_t;
  exp_t sb_q[$];

  ids_qos_arbiter #(.BURST_MAX(BMAX)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req_spi  (req_spi),
    .i_req_dmem (req_dmem),
    .i_req_dma  (req_dma),
    .i_lock     (lock),
    .o_gnt_spi  (gnt_spi),
    .o_gnt_dmem (gnt_dmem),
    .o_gnt_dma  (gnt_dma),
    .o_gnt_id   (gnt_id),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] id2vec(input logic [1:0] id);
    case (id)
      2'd1:    return 3'b100;
      2'd2:    return 3'b010;
      2'd3:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  // Each entry states the grant id expected after the coming clock edge.
  task automatic drive(input logic s, input logic d, input logic m, input logic l,
                       input int unsigned n, input logic [1:0] id);
    for (int unsigned i = 0; i < n; i++) begin
      req_spi = s; req_dmem = d; req_dma = m; lock = l;
      sb_q.push_back('{cyc: cyc + 1, id: id});
      @(posedge clk); #1;
    end
  endtask

  // Monitor: scoreboard pops plus per-cycle invariants.
  logic [1:0]  prev_id;
  logic        prev_valid = 1'b0;
  logic        prev_s, prev_d, prev_m, prev_l;
  int unsigned prev_ten;

  always @(negedge clk) begin
    logic [2:0]  vec;
    exp_t        e;
    logic        own, oth;
    int unsigned ten;
    if (rst_n) begin
      while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        e = sb_q.pop_front();
        checks++; failures++;
        $display("FAIL sb_missed: expected id %0d for cycle %0d never compared", e.id, e.cyc);
      end
      if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
        e = sb_q.pop_front();
        chk("gnt_id", gnt_id, e.id);
        chk("gnt_vec", {gnt_spi, gnt_dmem, gnt_dma}, id2vec(e.id));
      end
      vec = {gnt_spi, gnt_dmem, gnt_dma};
      chk("onehot", ($countones(vec) <= 1), 1);
      chk("id_vs_vec", vec, id2vec(gnt_id));
      chk("busy", busy, (vec != 3'b000));
      if (prev_valid && (prev_id == 2'd2 || prev_id == 2'd3)) begin
        own = (prev_id == 2'd2) ? prev_d : prev_m;
        oth = prev_s || ((prev_id == 2'd2) ? prev_m : prev_d);
        if (!own || (prev_ten >= BMAX && oth && !prev_l))
          chk("handover", (gnt_id != prev_id), 1);
      end
      ten = (prev_valid && gnt_id == prev_id && gnt_id != 2'd0) ? prev_ten + 1 : 1;
      prev_ten   = ten;
      prev_id    = gnt_id;
      prev_s     = req_spi; prev_d = req_dmem; prev_m = req_dma; prev_l = lock;
      prev_valid = 1'b1;
    end else begin
      prev_valid = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_spi = 1'b0; req_dmem = 1'b0; req_dma = 1'b0; lock = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_id", gnt_id, 0);
    chk("rst_vec", {gnt_spi, gnt_dmem, gnt_dma}, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Contended DMEM/DMA: 16 DMEM cycles, 16 DMA cycles, back to DMEM.
    drive(0, 1, 1, 0, 16, 2);
    drive(0, 1, 1, 0, 16, 3);
    drive(0, 1, 1, 0, 1, 2);
    // DMEM drops, DMA takes over; lock held 30 cycles with DMEM waiting.
    drive(0, 0, 1, 0, 1, 3);
    drive(0, 1, 1, 1, 30, 3);
    drive(0, 1, 1, 0, 1, 2);
    // DMEM owner reaches count 5, SPI waits until the quota expires.
    drive(0, 1, 0, 0, 5, 2);
    drive(1, 1, 0, 0, 10, 2);
    drive(1, 1, 0, 0, 1, 1);
    drive(1, 1, 1, 0, 20, 1);
    drive(0, 1, 1, 0, 1, 3);
    drive(0, 0, 0, 0, 2, 0);
    // Sole DMEM requester for 40 cycles keeps its grant.
    drive(0, 1, 0, 0, 40, 2);
    drive(0, 0, 0, 0, 1, 0);
    // SPI grant latency from IDLE, then tie goes to DMA after DMEM was last.
    drive(1, 0, 0, 0, 3, 1);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 1, 1, 0, 1, 3);
    drive(0, 1, 1, 0, 3, 3);

    // Asynchronous reset pulse mid-grant.
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst_id", gnt_id, 0);
    chk("arst_vec", {gnt_spi, gnt_dmem, gnt_dma}, 0);
    chk("arst_busy", busy, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("arst_hold_id", gnt_id, 0);
    rst_n = 1'b1;
    drive(0, 1, 1, 0, 1, 2);
    drive(0, 1, 1, 0, 2, 2);
    drive(0, 0, 0, 0, 1, 0);

    // Random traffic: only the invariants in the monitor apply here.
    for (int unsigned i = 0; i < 3000; i++) begin
      req_spi  = ($urandom_range(0, 9) == 0);
      req_dmem = ($urandom_range(0, 3) != 0);
      req_dma  = ($urandom_range(0, 3) != 0);
      lock     = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
    end
    req_spi = 1'b0; req_dmem = 1'b0; req_dma = 1'b0; lock = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
